// File: rtl/reg_cla_adder.sv
// Registered carry-lookahead adder: {co, s} = a + b + ci, lookahead within GROUP-bit groups, ripple between groups.
// Define REG_CLA_ADDER_IN_REG_EN to add a reset-to-zero input register stage (latency 2 instead of 1).
module reg_cla_adder #(
  parameter int WIDTH = 4,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:1]   a,
  input  logic [WIDTH:1]   b,
  input  logic             ci,
  output logic [WIDTH:1]   s,
  output logic             co
);

  logic [WIDTH:1] a_p0;
  logic [WIDTH:1] b_p0;
  logic           ci_p0;
  logic [WIDTH:1] s_next;
  logic           co_next;

  // First bit index of the lookahead group containing bit i.
  function automatic int grp_start(input int i);
    return ((i - 1) / GROUP) * GROUP + 1;
  endfunction

  // ---- stage p0: operands (optionally registered) ----
`ifdef REG_CLA_ADDER_IN_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0  <= '0;
      b_p0  <= '0;
      ci_p0 <= 1'b0;
    end else begin
      a_p0  <= a;
      b_p0  <= b;
      ci_p0 <= ci;
    end
  end
`else
  assign a_p0  = a;
  assign b_p0  = b;
  assign ci_p0 = ci;
`endif

  // ---- lookahead: each carry is a flat sum-of-products of g/p and the group carry-in ----
  always_comb begin
    logic [WIDTH:1]   g;
    logic [WIDTH:1]   p;
    logic [WIDTH+1:1] cy;
    logic             term;
    logic             prod;
    int               gs;
    g    = a_p0 & b_p0;
    p    = a_p0 ^ b_p0;
    cy   = '0;
    term = 1'b0;
    prod = 1'b0;
    gs   = 1;
    cy[1] = ci_p0;
    for (int i = 1; i <= WIDTH; i++) begin
      gs   = grp_start(i);
      term = g[i];
      prod = p[i];
      for (int j = i - 1; j >= gs; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      // cy[gs] is the previous group's carry-out (or ci for the first group)
      cy[i+1] = term | (prod & cy[gs]);
    end
    s_next  = p ^ cy[WIDTH:1];
    co_next = cy[WIDTH+1];
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s  <= '0;
      co <= 1'b0;
    end else begin
      s  <= s_next;
      co <= co_next;
    end
  end

endmodule

// File: tb/tb_reg_cla_adder.sv
// Scoreboard bench for reg_cla_adder: 4-bit directed/exhaustive vectors plus a 7-bit (partial group) random run.
module tb_reg_cla_adder;
`ifdef REG_CLA_ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [6:0] s;
    logic       co;
    int         due;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:1] a4 = '0, b4 = '0, s4;
  logic       ci4 = 1'b0, co4;
  logic [7:1] a7 = '0, b7 = '0, s7;
  logic       ci7 = 1'b0, co7;

  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;
  exp_t q4[$];
  exp_t q7[$];

  reg_cla_adder #(.WIDTH(4), .GROUP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .ci(ci4), .s(s4), .co(co4));
  reg_cla_adder #(.WIDTH(7), .GROUP(4)) u7 (
    .clk(clk), .rst_n(rst_n), .a(a7), .b(b7), .ci(ci7), .s(s7), .co(co7));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [6:0] got_s, input logic got_co,
                       input logic [6:0] want_s, input logic want_co);
    nvec++;
    if (got_s !== want_s || got_co !== want_co) begin
      nfail++;
      $display("FAIL %s: got s=%b co=%b, want s=%b co=%b", name, got_s, got_co, want_s, want_co);
    end
  endtask

  // Apply a 4-bit vector at a falling edge and queue its hand-computed result.
  task automatic apply4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic [3:0] es, input logic eco, input int id);
    exp_t e;
    @(negedge clk);
    a4 = a; b4 = b; ci4 = ci;
    e.s = {3'b0, es}; e.co = eco; e.due = cyc + LAT; e.id = id;
    q4.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    while (q4.size() > 0 && q4[0].due <= cyc) begin
      exp_t e;
      e = q4.pop_front();
      if (e.due != cyc) begin
        nvec++; nfail++;
        $display("FAIL w4 #%0d late: checked at cycle %0d, required %0d", e.id, cyc, e.due);
      end else
        check($sformatf("w4 #%0d", e.id), {3'b0, s4}, co4, e.s, e.co);
    end
    while (q7.size() > 0 && q7[0].due <= cyc) begin
      exp_t e;
      e = q7.pop_front();
      check($sformatf("w7 #%0d", e.id), s7, co7, e.s, e.co);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  typedef struct { logic [3:0] a, b; logic ci; logic [3:0] s; logic co; } vec_t;
  vec_t dir[12] = '{
    '{4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0},
    '{4'b0010, 4'b0011, 1'b1, 4'b0110, 1'b0},
    '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0},
    '{4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0},
    '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0},
    '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1},
    '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1},
    '{4'b1000, 4'b1000, 1'b1, 4'b0001, 1'b1},
    '{4'b0110, 4'b1001, 1'b0, 4'b1111, 1'b0},
    '{4'b0110, 4'b1001, 1'b1, 4'b0000, 1'b1},
    '{4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b0},
    '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1}
  };

  initial begin
    int sum;
    exp_t e;
    // Reset held with all-ones operands: outputs must stay clear.
    a4 = 4'b1111; b4 = 4'b1111; ci4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset hold", {3'b0, s4}, co4, 7'd0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e.s = 7'b0001111; e.co = 1'b1; e.due = cyc + LAT; e.id = 100;
    q4.push_back(e);

    for (int k = 0; k < 12; k++)
      apply4(dir[k].a, dir[k].b, dir[k].ci, dir[k].s, dir[k].co, k);

    // Let the last result settle, then pulse reset between edges.
    repeat (LAT + 1) @(negedge clk);
    check("before async reset", {3'b0, s4}, co4, 7'b0001110, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async reset", {3'b0, s4}, co4, 7'd0, 1'b0);
    @(negedge clk);
    check("reset after edge", {3'b0, s4}, co4, 7'd0, 1'b0);
    rst_n = 1'b1;

    for (int v = 0; v < 512; v++) begin
      sum = (v & 15) + ((v >> 4) & 15) + ((v >> 8) & 1);
      apply4(4'(v), 4'(v >> 4), 1'(v >> 8), 4'(sum), sum[4], 200 + v);
    end

    for (int k = 0; k < 200; k++) begin
      int ra, rb, rc;
      ra = $urandom_range(127, 0); rb = $urandom_range(127, 0); rc = $urandom_range(1, 0);
      if (k == 0) begin ra = 127; rb = 0; rc = 1; end
      if (k == 1) begin ra = 127; rb = 127; rc = 1; end
      if (k == 2) begin ra = 15; rb = 1; rc = 0; end
      sum = ra + rb + rc;
      @(negedge clk);
      a7 = 7'(ra); b7 = 7'(rb); ci7 = 1'(rc);
      e.s = 7'(sum); e.co = sum[7]; e.due = cyc + LAT; e.id = k;
      q7.push_back(e);
    end

    repeat (LAT + 2) @(negedge clk);
    nvec++;
    if (q4.size() + q7.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending results, want 0", q4.size() + q7.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/reg_cla_adder.md
Name: reg_cla_adder

Overview:
- Clocked binary adder computing {co, s} = a + b + ci using carry-lookahead logic.
- Result held in output registers, so downstream logic sees a stable sum for a full clock period.
- Default configuration is a 4-bit adder: the top-level arithmetic datapath block of the VLSI exercise set.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range 1..32.
- GROUP, 4, carry-lookahead group size in bits; carries ripple between groups; last group may be partial.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, indexed [WIDTH:1], bit 1 = LSB.
- b  input  WIDTH  operand B, indexed [WIDTH:1], bit 1 = LSB.
- ci  input  1  carry-in.
- s  output  WIDTH  registered sum, indexed [WIDTH:1].
- co  output  1  registered carry-out.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low forces s = 0 and co = 0 immediately, independent of clk.
  - Deassertion is sampled on the next rising clk edge.
  - Reset asserted mid-operation discards any in-flight result.
- Datapath:
  - Per bit: g[i] = a[i] & b[i], p[i] = a[i] ^ b[i].
  - Within a group, lookahead: c[i+1] = g[i] | p[i]&c[i], expanded to two-level sum-of-products per group. No ripple inside a group.
  - Group carry-out feeds the next group's carry-in. The first group's carry-in is ci.
  - Sum bit: s_next[i] = p[i] ^ c[i]. co_next = carry out of bit WIDTH.
- Arithmetic: unsigned, modulo 2^WIDTH. co = 1 exactly when a + b + ci >= 2^WIDTH. No saturation.
- Timing:
  - a, b, ci are sampled at rising clk edge N.
  - {co, s} = a + b + ci is visible after edge N. Latency is 1 cycle.
  - New operands are accepted every cycle (throughput 1/cycle). No handshake.
- Hold: outputs change only at clock edges or on reset. Input glitches between edges have no effect.
- Boundaries (WIDTH = 4):
  - 0 + 0 + 0 -> s = 0000, co = 0.
  - 1111 + 1111 + 1 -> s = 1111, co = 1.
  - 1111 + 0000 + 1 -> s = 0000, co = 1. Full propagate chain.
- X/Z on inputs is not required to be handled; outputs may be X.

Optional Feature:
- Macro: REG_CLA_ADDER_IN_REG_EN.
- Defined:
  - Adds an input register stage on a, b, ci, also reset to 0 by rst_n.
  - Lookahead logic sits between the input and output registers.
  - Latency becomes 2 cycles; throughput stays 1/cycle.
  - The first valid result appears 2 edges after reset release.
- Undefined:
  - No input registers; 1-cycle latency as in Behaviour.
- The port list is identical in both builds.

Test Plan:
- Reset: hold rst_n = 0 with a = 1111, b = 1111, ci = 1, clocks running -> s = 0000, co = 0 throughout. Release -> next edge gives s = 1111, co = 1.
- Back-to-back vectors, one per cycle:
  - 0001 + 0001 + 0 -> 0010/0.
  - 0010 + 0011 + 1 -> 0110/0.
  - 0101 + 0011 + 0 -> 1000/0.
  - 0101 + 0011 + 1 -> 1001/0.
  - Each result appears exactly 1 cycle after its inputs (2 with REG_CLA_ADDER_IN_REG_EN).
- Overflow:
  - 1000 + 1000 + 0 -> s = 0000, co = 1.
  - 1000 + 1000 + 1 -> s = 0001, co = 1.
  - 1111 + 1111 + 0 -> s = 1110, co = 1.
- Propagate chain:
  - 0110 + 1001 + 0 -> 1111/0.
  - 0110 + 1001 + 1 -> 0000/1.
  - 0111 + 0111 + 1 -> 1111/0.
- Asynchronous reset mid-stream: assert rst_n = 0 between clock edges while a result is registered -> s and co clear immediately, before the next edge.
- Exhaustive: all 512 combinations of a, b, ci over consecutive cycles, compared against a + b + ci. Repeat with WIDTH = 7, GROUP = 4 (partial last group) on random vectors.
